expmul_pipe: RTL and testbench
==============================

// Module: expmul_pipe
// PURPOSE
//  Parametrised elastic exp-scale unit for the online-softmax datapath: v_out[i] = 2^k * v_in[i],
//  k = round(log2e*(a-b)), log2e approximated by shift-add. Sits between score/max tracking and the
//  O*/denominator accumulator; LANES covers embedding lanes plus the running-sum lane. Adds
//  rounding right-shift, saturating left-shift, pass mode, full backpressure and a beat counter.
// PARAMETERS
//  LANES    65   vector lanes (embedding dim + 1 sum lane)
//  VEC_W    26   signed lane width (two's complement)
//  VEC_F    17   lane fraction bits (documentation only; shift is format-agnostic)
//  DIFF_W   8    signed width of a/b
//  DIFF_F   4    fraction bits of a/b
//  SEQ_LEN  128  beats per KV tile; counter wraps at SEQ_LEN-1 (>=2)
// PORTS
//  clock     in   1                clock
//  reset     in   1                reset, synchronous, active-high
//  in_vld    in   1                input beat valid
//  in_rdy    out  1                input beat accepted when in_vld&in_rdy
//  in_a      in   DIFF_W           score (signed QI.DIFF_F)
//  in_b      in   DIFF_W           running max (signed QI.DIFF_F)
//  in_v      in   LANES*VEC_W      lane vector, lane i at [i*VEC_W +: VEC_W]
//  in_pass   in   1                1: force k=0 (v passes unscaled); sampled with beat
//  out_vld   out  1                output beat valid
//  out_rdy   in   1                downstream ready
//  out_v     out  LANES*VEC_W      scaled vector
//  out_sat   out  1                any lane saturated on this beat
//  out_last  out  1                beat is index SEQ_LEN-1 of tile
//  out_idx   out  $clog2(SEQ_LEN)  beat index within tile
// BEHAVIOUR
//  - Reset: in_rdy=1 after reset; out_vld=0, out_v=0, out_sat=0, out_last=0, out_idx=0; both stages empty.
//  - Two registered stages, elastic: s2_rdy = !s2_vld | out_rdy; s1_rdy = !s1_vld | s2_rdy; in_rdy = s1_rdy.
//    Beat accepted at edge t -> out_vld from edge t+2. Throughput 1 beat/cycle with out_rdy=1.
//  - out_* stable while out_vld&!out_rdy; no beat dropped or duplicated under any backpressure pattern.
//  - S1 holds a,b,v,pass. Combinational: d = a-b (DIFF_W+1 signed, exact);
//    t = d + (d>>>1) - (d>>>4) (DIFF_W+3 signed, DIFF_F frac, arithmetic shifts);
//    k = floor(t + 0.5) (round half up); clamp k to [-VEC_W, +VEC_W]; pass=1 -> k=0. k registered into S2 with v.
//  - S2 output (combinational from S2 regs), per lane:
//    k<0: y = floor((v + 2^(-k-1)) / 2^-k) via arithmetic shift; k=-VEC_W yields 0 or -1.
//    k=0: y = v.  k>0: y = v<<<k saturated to [-2^(VEC_W-1), 2^(VEC_W-1)-1]; lane sat flag set.
//    Right-shift rounding add must not overflow: compute in VEC_W+1 bits, result fits VEC_W.
//  - out_sat = OR of lane sat flags of the presented beat.
//  - Counter cnt increments on out_vld&out_rdy; wraps SEQ_LEN-1 -> 0. out_idx=cnt; out_last=(cnt==SEQ_LEN-1).
//  - Simultaneous S1->S2 move and new input accept in same cycle is legal and required.
//  - Reset mid-operation: all in-flight beats discarded, cnt=0, no out_vld the cycle after reset.
// STRUCTURE
//  - Package expmul_pkg: k width function/localparam (K_W = $clog2(VEC_W)+2), lane vector typedef,
//    log2e shift-add function, rounding constant helper.
//  - Sub-module expmul_lane_shift (VEC_W): one lane, inputs v,k -> y,sat; generate LANES copies.
//  - Top holds handshake regs, k computation, counter.
// TESTING (DIFF_F=4, VEC_W=26, SEQ_LEN=4 for counter tests)
//  1 a=b=0x10, v[i]=i*3, pass=0 -> k=0, out_v==in_v, sat=0, out_vld 2 cycles after accept.
//  2 a=0x00,b=0x10 (d=-16, t=-23) -> k=-1; v=256 -> 128; v=3 -> 2; v=-3 -> -1.
//  3 a=0x00,b=0x20 (d=-32, t=-46) -> k=-3; v=100 -> 13; b-a=0x7F+ large -> k clamps -26, v>0 -> 0.
//  4 a=0x40,b=0x00 (d=64, t=92) -> k=6; v=2^24 -> 2^25-1, out_sat=1; v=-2^24 -> -2^25, sat=1.
//  5 random stream, random out_rdy (30% low), random in_vld -> output sequence equals golden model, no loss.
//  6 8 beats -> out_idx 0,1,2,3,0,1,2,3, out_last on 4th/8th; pass=1 beat with d=-16 -> unscaled;
//    reset asserted with 2 beats in flight -> no outputs, out_idx=0 on next beat.

Source files
------------

// File: rtl/expmul_pkg.sv
// Shared types and arithmetic helpers for the exp-scale pipeline: default sizes, k width,
// log2(e) shift-add scaling and the rounding bias used by the lane right-shift.
package expmul_pkg;

  localparam int unsigned LANES_DEF   = 65;
  localparam int unsigned VEC_W_DEF   = 26;
  localparam int unsigned DIFF_W_DEF  = 8;
  localparam int unsigned DIFF_F_DEF  = 4;
  localparam int unsigned SEQ_LEN_DEF = 128;

  typedef logic [LANES_DEF*VEC_W_DEF-1:0] lane_vec_t;

  // Signed k must hold +/-vec_w.
  function automatic int unsigned k_width(int unsigned vec_w);
    return $clog2(vec_w) + 2;
  endfunction

  // k = round-half-up(d * 1.4375) in integer units, clamped to +/-vec_w.
  function automatic int log2e_k(int d, int unsigned diff_f, int unsigned vec_w);
    int t;
    int half;
    int k;
    t    = d + (d >>> 1) - (d >>> 4);
    half = (diff_f == 0) ? 0 : (1 << (diff_f - 1));
    k    = (t + half) >>> diff_f;
    if (k > int'(vec_w)) begin
      k = int'(vec_w);
    end else if (k < -int'(vec_w)) begin
      k = -int'(vec_w);
    end
    return k;
  endfunction

  function automatic int round_bias(int unsigned sh);
    return (sh == 0) ? 0 : (1 << (sh - 1));
  endfunction

endpackage

// File: rtl/expmul_pipe_if.sv
// Handshake bundle for expmul_pipe: input beat channel and scaled output channel.
interface expmul_pipe_if import expmul_pkg::*; #(
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned VEC_W   = VEC_W_DEF,
  parameter int unsigned DIFF_W  = DIFF_W_DEF,
  parameter int unsigned SEQ_LEN = SEQ_LEN_DEF
);
  localparam int unsigned IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic                     in_vld;
  logic                     in_rdy;
  logic signed [DIFF_W-1:0] in_a;
  logic signed [DIFF_W-1:0] in_b;
  logic [LANES*VEC_W-1:0]   in_v;
  logic                     in_pass;
  logic                     out_vld;
  logic                     out_rdy;
  logic [LANES*VEC_W-1:0]   out_v;
  logic                     out_sat;
  logic                     out_last;
  logic [IDX_W-1:0]         out_idx;

  modport master (
    output in_vld, in_a, in_b, in_v, in_pass, out_rdy,
    input  in_rdy, out_vld, out_v, out_sat, out_last, out_idx
  );

  modport slave (
    input  in_vld, in_a, in_b, in_v, in_pass, out_rdy,
    output in_rdy, out_vld, out_v, out_sat, out_last, out_idx
  );

endinterface

// File: rtl/expmul_lane_shift.sv
// One lane of the 2^k scaler: rounding arithmetic right shift for k<0, saturating
// left shift for k>0, pass-through for k=0.
module expmul_lane_shift import expmul_pkg::*; #(
  parameter int unsigned VEC_W = VEC_W_DEF,
  parameter int unsigned K_W   = k_width(VEC_W)
) (
  input  logic signed [VEC_W-1:0] v,
  input  logic signed [K_W-1:0]   k,
  output logic signed [VEC_W-1:0] y,
  output logic                    sat
);

  localparam logic signed [2*VEC_W-1:0] WIDE_MAX = {{(VEC_W+1){1'b0}}, {(VEC_W-1){1'b1}}};
  localparam logic signed [2*VEC_W-1:0] WIDE_MIN = {{(VEC_W+1){1'b1}}, {(VEC_W-1){1'b0}}};
  localparam logic signed [VEC_W-1:0]   Y_MAX    = {1'b0, {(VEC_W-1){1'b1}}};
  localparam logic signed [VEC_W-1:0]   Y_MIN    = {1'b1, {(VEC_W-1){1'b0}}};

  logic signed [VEC_W:0]     rnd_sum;
  logic signed [2*VEC_W-1:0] shl;
  int unsigned               sh;

  always_comb begin
    sh      = 0;
    rnd_sum = '0;
    shl     = '0;
    y       = v;
    sat     = 1'b0;
    if (k < 0) begin
      sh      = -int'(k);
      // One extra bit keeps v + bias from wrapping at the positive rail.
      rnd_sum = {v[VEC_W-1], v} + (VEC_W+1)'(round_bias(sh));
      y       = VEC_W'(rnd_sum >>> sh);
    end else if (k > 0) begin
      sh  = int'(k);
      shl = {{VEC_W{v[VEC_W-1]}}, v} <<< sh;
      if (shl > WIDE_MAX) begin
        y   = Y_MAX;
        sat = 1'b1;
      end else if (shl < WIDE_MIN) begin
        y   = Y_MIN;
        sat = 1'b1;
      end else begin
        y = shl[VEC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/expmul_pipe.sv
// Two-stage elastic exp-scale unit: v_out = 2^k * v_in with k = round(log2e*(a-b)),
// plus a wrapping beat counter on the output side.
module expmul_pipe import expmul_pkg::*; #(
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned VEC_W   = VEC_W_DEF,
  parameter int unsigned DIFF_W  = DIFF_W_DEF,
  parameter int unsigned DIFF_F  = DIFF_F_DEF,
  parameter int unsigned SEQ_LEN = SEQ_LEN_DEF
) (
  input logic         clock,
  input logic         reset,
  expmul_pipe_if.slave bus
);

  localparam int unsigned      KW       = k_width(VEC_W);
  localparam int unsigned      IDX_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  logic                     s1_vld;
  logic                     s2_vld;
  logic                     s1_rdy;
  logic                     s2_rdy;
  logic signed [DIFF_W-1:0] s1_a;
  logic signed [DIFF_W-1:0] s1_b;
  logic [LANES*VEC_W-1:0]   s1_v;
  logic                     s1_pass;
  logic [LANES*VEC_W-1:0]   s2_v;
  logic signed [KW-1:0]     s2_k;
  logic signed [KW-1:0]     k_d;
  logic signed [DIFF_W:0]   diff;
  logic [LANES*VEC_W-1:0]   lane_y;
  logic [LANES-1:0]         lane_sat;
  logic [IDX_W-1:0]         cnt;

  always_comb begin
    s2_rdy = !s2_vld || bus.out_rdy;
    s1_rdy = !s1_vld || s2_rdy;
  end

  always_comb begin
    diff = {s1_a[DIFF_W-1], s1_a} - {s1_b[DIFF_W-1], s1_b};
    k_d  = '0;
    if (!s1_pass) begin
      k_d = KW'(log2e_k(int'(diff), DIFF_F, VEC_W));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_v    <= '0;
      s1_pass <= 1'b0;
      s2_vld  <= 1'b0;
      s2_k    <= '0;
      s2_v    <= '0;
    end else begin
      if (s1_rdy) begin
        s1_vld <= bus.in_vld;
      end
      if (bus.in_vld && s1_rdy) begin
        s1_a    <= bus.in_a;
        s1_b    <= bus.in_b;
        s1_v    <= bus.in_v;
        s1_pass <= bus.in_pass;
      end
      if (s2_rdy) begin
        s2_vld <= s1_vld;
      end
      if (s1_vld && s2_rdy) begin
        s2_k <= k_d;
        s2_v <= s1_v;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (s2_vld && bus.out_rdy) begin
      cnt <= (cnt == LAST_IDX) ? '0 : cnt + IDX_W'(1);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    expmul_lane_shift #(
      .VEC_W (VEC_W),
      .K_W   (KW)
    ) u_shift (
      .v   (s2_v[i*VEC_W +: VEC_W]),
      .k   (s2_k),
      .y   (lane_y[i*VEC_W +: VEC_W]),
      .sat (lane_sat[i])
    );
  end

  assign bus.in_rdy   = s1_rdy;
  assign bus.out_vld  = s2_vld;
  assign bus.out_v    = lane_y;
  assign bus.out_sat  = |lane_sat;
  assign bus.out_last = (cnt == LAST_IDX);
  assign bus.out_idx  = cnt;

endmodule

// File: tb/tb_expmul_pipe.sv
// Scoreboard bench for expmul_pipe: driver pushes model results, monitor pops and compares.
module tb_expmul_pipe;

  localparam int L   = 8;
  localparam int VW  = 26;
  localparam int DW  = 8;
  localparam int DF  = 4;
  localparam int SEQ = 4;
  localparam int IW  = $clog2(SEQ);

  typedef logic [L*VW-1:0] vec_t;
  typedef struct {
    vec_t v;
    bit   sat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  expmul_pipe_if #(.LANES(L), .VEC_W(VW), .DIFF_W(DW), .SEQ_LEN(SEQ)) bus ();

  expmul_pipe #(
    .LANES   (L),
    .VEC_W   (VW),
    .DIFF_W  (DW),
    .DIFF_F  (DF),
    .SEQ_LEN (SEQ)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mon_cnt = 0;
  int   rdy_pct = 0;

  // ---------------- reference model ----------------
  function automatic longint fdiv(longint a, longint b);
    longint r;
    r = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) r = r - 1;
    return r;
  endfunction

  function automatic int ref_k(int d);
    int t;
    int k;
    t = d + int'(fdiv(d, 2)) - int'(fdiv(d, 16));
    k = int'(fdiv(t + 8, 16));
    if (k > VW) k = VW;
    if (k < -VW) k = -VW;
    return k;
  endfunction

  function automatic void ref_lane(input longint x, input int k, output longint y, output bit s);
    longint hi;
    longint lo;
    hi = (longint'(1) << (VW - 1)) - 1;
    lo = -(longint'(1) << (VW - 1));
    s  = 1'b0;
    if (k < 0) begin
      y = fdiv(x + (longint'(1) << (-k - 1)), longint'(1) << (-k));
    end else begin
      y = x * (longint'(1) << k);
      if (y > hi) begin
        y = hi; s = 1'b1;
      end else if (y < lo) begin
        y = lo; s = 1'b1;
      end
    end
  endfunction

  function automatic exp_t ref_beat(input int a, input int b, input vec_t v, input bit pass);
    exp_t   r;
    int     k;
    longint x;
    longint y;
    bit     s;
    k     = pass ? 0 : ref_k(a - b);
    r.v   = '0;
    r.sat = 1'b0;
    for (int i = 0; i < L; i++) begin
      x = longint'($signed(v[i*VW +: VW]));
      ref_lane(x, k, y, s);
      r.v[i*VW +: VW] = y[VW-1:0];
      r.sat = r.sat | s;
    end
    return r;
  endfunction

  function automatic vec_t pack8(longint l0, longint l1, longint l2, longint l3,
                                 longint l4, longint l5, longint l6, longint l7);
    vec_t   v;
    longint l[8];
    l = '{l0, l1, l2, l3, l4, l5, l6, l7};
    for (int i = 0; i < L; i++) v[i*VW +: VW] = l[i][VW-1:0];
    return v;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic drive_rdy();
    bus.out_rdy = (rdy_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= rdy_pct);
  endtask

  task automatic send(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                      input vec_t v, input bit pass);
    int guard;
    guard = 0;
    @(negedge clock);
    bus.in_vld  = 1'b1;
    bus.in_a    = a;
    bus.in_b    = b;
    bus.in_v    = v;
    bus.in_pass = pass;
    drive_rdy();
    #1;
    while (bus.in_rdy !== 1'b1 && guard < 100) begin
      @(negedge clock);
      drive_rdy();
      #1;
      guard++;
    end
    n_tests++;
    if (bus.in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout in_rdy=%b want=1", bus.in_rdy);
    end else begin
      q.push_back(ref_beat(int'(a), int'(b), v, pass));
    end
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_vld = 1'b0;
    drive_rdy();
  endtask

  task automatic drain();
    int guard;
    guard   = 0;
    rdy_pct = 0;
    while (q.size() > 0 && guard < 200) begin
      idle();
      guard++;
    end
    repeat (3) idle();
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  exp_t             mon_e;
  bit               hold_valid = 1'b0;
  vec_t             held_v;
  logic             held_sat;
  logic [IW-1:0]    held_idx;

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        hold_valid = 1'b0;
        mon_cnt    = 0;
      end else begin
        if (hold_valid) begin
          n_tests++;
          if (bus.out_vld !== 1'b1 || bus.out_v !== held_v || bus.out_sat !== held_sat ||
              bus.out_idx !== held_idx) begin
            n_fail++;
            $display("FAIL hold_stable vld=%b v=%h sat=%b idx=%0d want v=%h sat=%b idx=%0d",
                     bus.out_vld, bus.out_v, bus.out_sat, bus.out_idx,
                     held_v, held_sat, held_idx);
          end
        end
        hold_valid = (bus.out_vld === 1'b1) && (bus.out_rdy === 1'b0);
        held_v     = bus.out_v;
        held_sat   = bus.out_sat;
        held_idx   = bus.out_idx;
        if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat v=%h want no beat", bus.out_v);
          end else begin
            mon_e = q.pop_front();
            if (bus.out_v !== mon_e.v || bus.out_sat !== mon_e.sat ||
                bus.out_idx !== IW'(mon_cnt) || bus.out_last !== (mon_cnt == SEQ - 1)) begin
              n_fail++;
              $display("FAIL beat v=%h sat=%b idx=%0d last=%b want v=%h sat=%b idx=%0d last=%b",
                       bus.out_v, bus.out_sat, bus.out_idx, bus.out_last,
                       mon_e.v, mon_e.sat, mon_cnt, (mon_cnt == SEQ - 1));
            end
          end
          mon_cnt = (mon_cnt + 1) % SEQ;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t   v;
    longint lane;
    bus.in_vld  = 1'b0;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.in_v    = '0;
    bus.in_pass = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    chk("rst_out_vld", 64'(bus.out_vld), 64'd0);
    chk("rst_out_v_zero", 64'(|bus.out_v), 64'd0);
    chk("rst_out_sat", 64'(bus.out_sat), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_out_idx", 64'(bus.out_idx), 64'd0);

    // k = 0 pass-through and two-cycle latency
    v = pack8(0, 3, 6, 9, 12, 15, 18, 21);
    send(8'h10, 8'h10, v, 1'b0);
    idle(); #3; chk("latency_edge1_vld", 64'(bus.out_vld), 64'd0);
    idle(); #3; chk("latency_edge2_vld", 64'(bus.out_vld), 64'd1);

    // k = -1 rounding, k = -3, very negative k
    send(8'h00, 8'h10, pack8(256, 3, -3, 1, -1, -256, 33554431, -33554432), 1'b0);
    send(8'h00, 8'h20, pack8(100, -100, 4, -4, 5, -5, 33554431, -33554432), 1'b0);
    send(8'h80, 8'h7F, pack8(100, -100, 1, -1, 4194304, -4194304, 33554431, -33554432), 1'b0);
    // k > 0 with and without saturation
    send(8'h40, 8'h00, pack8(16777216, -16777216, 1, -1, 0, 262143, -262144, 262144), 1'b0);
    send(8'h7F, 8'h80, pack8(5, -5, 1, 0, -1, 3, 2, -2), 1'b0);
    send(8'h10, 8'h00, pack8(7, -7, 100, -100, 0, 1, -1, 2), 1'b0);
    // pass overrides k
    send(8'h00, 8'h10, pack8(3, -3, 256, -256, 1, -1, 33554431, -33554432), 1'b1);
    drain();

    // random stream under random backpressure
    rdy_pct = 30;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 25) begin
        idle();
      end else begin
        for (int i = 0; i < L; i++) begin
          if ($urandom_range(0, 3) == 0) lane = longint'($urandom_range(0, 2000)) - 1000;
          else lane = longint'($signed(26'($urandom)));
          v[i*VW +: VW] = lane[VW-1:0];
        end
        send(8'($urandom), 8'($urandom), v, ($urandom_range(0, 9) == 0));
      end
    end
    drain();

    // reset with two beats in flight
    rdy_pct = 100;
    send(8'h00, 8'h10, pack8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0);
    send(8'h00, 8'h20, pack8(9, 10, 11, 12, 13, 14, 15, 16), 1'b0);
    @(negedge clock);
    reset      = 1'b1;
    bus.in_vld = 1'b0;
    q.delete();
    @(negedge clock);
    reset       = 1'b0;
    rdy_pct     = 0;
    bus.out_rdy = 1'b1;
    #3;
    chk("post_reset_out_vld", 64'(bus.out_vld), 64'd0);
    chk("post_reset_out_idx", 64'(bus.out_idx), 64'd0);

    // eight back-to-back beats exercise the counter wrap
    for (int n = 0; n < 8; n++) begin
      send(8'(n * 16), 8'h20, pack8(n, -n, 100 * n, 1000, -1000, 7, 8, 9), 1'b0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
